// File: rtl/jump_physics.sv
// -----------------------------------------------------------------------------
// jump_physics
// Responder side of the jump handshake. When the game FSM raises i_jump_en the
// initial velocity is latched (saturated to 127) and a discrete ballistic arc
// is integrated once per physics tick. Height and distance stream out every
// cycle; on landing o_jump_done is raised and held until the FSM drops enable.
//
// Ports:
//   clk_jump       in   1  system clock
//   rst_jump       in   1  synchronous, active-high reset
//   i_jump_en      in   1  level jump request from the FSM
//   i_jump_v_init  in  11  initial velocity (values above 127 saturate)
//   o_jump_dist    out 11  dist_acc >> D_SHIFT
//   o_jump_height  out  9  h_acc >> H_SHIFT
//   o_jump_done    out  1  landing flag, held while i_jump_en stays high
//   o_airborne     out  1  high exactly while in flight
// -----------------------------------------------------------------------------
module jump_physics #(
  parameter int unsigned TICK_CYCLES = 98000,
  parameter int unsigned H_SHIFT     = 5,
  parameter int unsigned D_SHIFT     = 7
) (
  input  logic        clk_jump,
  input  logic        rst_jump,
  input  logic        i_jump_en,
  input  logic [10:0] i_jump_v_init,
  output logic [10:0] o_jump_dist,
  output logic [8:0]  o_jump_height,
  output logic        o_jump_done,
  output logic        o_airborne
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TickLast = CW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFly, StDone} state_t;

  state_t             r_state;
  logic [6:0]         r_v;
  logic signed [7:0]  r_vy;
  logic [12:0]        r_h;
  logic [14:0]        r_dist;
  logic [CW-1:0]      r_tick;
  logic [10:0]        r_dist_o;
  logic [8:0]         r_height_o;
  logic               r_done;
  logic               r_airborne;

  logic [6:0]         w_v_sat;
  logic [13:0]        w_h_sum;
  logic               w_land;
  logic               w_tick_last;
  logic [10:0]        w_dist_out;
  logic [8:0]         w_h_out;

  assign w_v_sat     = (i_jump_v_init > 11'd127) ? 7'd127 : i_jump_v_init[6:0];
  // Height plus signed vertical velocity in 14-bit two's complement.
  assign w_h_sum     = {1'b0, r_h} + {{6{r_vy[7]}}, r_vy};
  // Landing only on the way down, once the sum reaches zero or goes negative.
  assign w_land      = r_vy[7] && (w_h_sum[13] || (w_h_sum == 14'd0));
  assign w_tick_last = (r_tick == TickLast);
  assign w_dist_out  = 11'(r_dist >> D_SHIFT);
  assign w_h_out     = 9'(r_h >> H_SHIFT);

  always_ff @(posedge clk_jump) begin
    if (rst_jump) begin
      r_state    <= StIdle;
      r_v        <= '0;
      r_vy       <= '0;
      r_h        <= '0;
      r_dist     <= '0;
      r_tick     <= '0;
      r_dist_o   <= '0;
      r_height_o <= '0;
      r_done     <= 1'b0;
      r_airborne <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Outputs hold their last values while idle.
          if (i_jump_en) begin
            r_v        <= w_v_sat;
            r_vy       <= $signed({1'b0, w_v_sat});
            r_h        <= '0;
            r_dist     <= '0;
            r_tick     <= '0;
            r_state    <= StFly;
            r_airborne <= 1'b1;
          end
        end

        StFly: begin
          r_dist_o   <= w_dist_out;
          r_height_o <= w_h_out;
          if (!i_jump_en) begin
            // Abort has priority over a coincident physics tick.
            r_state    <= StIdle;
            r_airborne <= 1'b0;
          end else if (w_tick_last) begin
            r_tick <= '0;
            r_dist <= 15'(r_dist + {8'd0, r_v});
            if (w_land) begin
              r_h        <= '0;
              r_state    <= StDone;
              r_airborne <= 1'b0;
            end else begin
              r_h  <= w_h_sum[12:0];
              r_vy <= r_vy - 8'sd1;
            end
          end else begin
            r_tick <= r_tick + CW'(1);
          end
        end

        StDone: begin
          r_dist_o   <= w_dist_out;
          r_height_o <= 9'd0;
          // Done drops on the same edge that returns to idle.
          r_done     <= i_jump_en;
          if (!i_jump_en) begin
            r_state <= StIdle;
          end
        end

        default: begin
          r_state    <= StIdle;
          r_airborne <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign o_jump_dist   = r_dist_o;
  assign o_jump_height = r_height_o;
  assign o_jump_done   = r_done;
  assign o_airborne    = r_airborne;

endmodule

// File: tb/tb_jump_physics.sv
// Bench for jump_physics: two instances (4-cycle tick and 1-cycle tick) share
// the same stimulus. A closed-form flight model predicts every output on every
// cycle; directed literal checks pin landing time, peak and final distance.
module tb_jump_physics;

  logic        clk;
  logic        rst;
  logic        en;
  logic [10:0] vin;

  logic [10:0] w_dist [2];
  logic [8:0]  w_h    [2];
  logic        w_done [2];
  logic        w_air  [2];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  jump_physics #(.TICK_CYCLES(4), .H_SHIFT(5), .D_SHIFT(7)) u_dut4 (
    .clk_jump      (clk),
    .rst_jump      (rst),
    .i_jump_en     (en),
    .i_jump_v_init (vin),
    .o_jump_dist   (w_dist[0]),
    .o_jump_height (w_h[0]),
    .o_jump_done   (w_done[0]),
    .o_airborne    (w_air[0])
  );

  jump_physics #(.TICK_CYCLES(1), .H_SHIFT(5), .D_SHIFT(7)) u_dut1 (
    .clk_jump      (clk),
    .rst_jump      (rst),
    .i_jump_en     (en),
    .i_jump_v_init (vin),
    .o_jump_dist   (w_dist[1]),
    .o_jump_height (w_h[1]),
    .o_jump_done   (w_done[1]),
    .o_airborne    (w_air[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Flight in closed form: after n ticks height = n*v - n(n-1)/2 and
  // distance = n*v; the jump lands after 2v+1 ticks (2 ticks when v=0).
  int tick_len [2] = '{4, 1};
  int m_mode [2];   // 0 idle, 1 flying, 2 landed
  int m_k    [2];   // edges since the jump was accepted
  int m_v    [2];
  int e_dist [2];
  int e_h    [2];
  int e_done [2];
  int e_air  [2];

  function automatic int n_land(input int v);
    return (v == 0) ? 2 : 2 * v + 1;
  endfunction

  function automatic int h_acc(input int v, input int n);
    if (n >= n_land(v)) return 0;
    return n * v - (n * (n - 1)) / 2;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int n;
      if (rst) begin
        m_mode[i] = 0; m_k[i] = 0; m_v[i] = 0;
        e_dist[i] = 0; e_h[i] = 0; e_done[i] = 0; e_air[i] = 0;
      end else begin
        case (m_mode[i])
          0: if (en) begin
            m_v[i]    = (vin > 127) ? 127 : int'(vin);
            m_k[i]    = 0;
            m_mode[i] = 1;
            e_air[i]  = 1;
          end
          1: begin
            n         = m_k[i] / tick_len[i];
            e_h[i]    = h_acc(m_v[i], n) >> 5;
            e_dist[i] = (n * m_v[i]) >> 7;
            if (!en) begin
              m_mode[i] = 0;
              e_air[i]  = 0;
            end else begin
              m_k[i]++;
              if (m_k[i] / tick_len[i] >= n_land(m_v[i])) begin
                m_mode[i] = 2;
                e_air[i]  = 0;
              end
            end
          end
          default: begin
            e_h[i]    = 0;
            e_dist[i] = (n_land(m_v[i]) * m_v[i]) >> 7;
            e_done[i] = en ? 1 : 0;
            if (!en) m_mode[i] = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dist[%0d]", i),   int'(w_dist[i]), e_dist[i]);
        chk($sformatf("height[%0d]", i), int'(w_h[i]),    e_h[i]);
        chk($sformatf("done[%0d]", i),   int'(w_done[i]), e_done[i]);
        chk($sformatf("air[%0d]", i),    int'(w_air[i]),  e_air[i]);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic start(input int v);
    @(negedge clk);
    vin = 11'(v);
    en  = 1'b1;
  endtask

  task automatic stop_jump(input int gap);
    @(negedge clk);
    en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Counts edges from the accepting edge (0) to the first edge with done high.
  task automatic run_until_done(input int idx, input int limit,
                                output int cyc, output int peak);
    int edges;
    edges = 0;
    peak  = 0;
    cyc   = -1;
    while (cyc < 0) begin
      @(posedge clk);
      #1;
      if (int'(w_h[idx]) > peak) peak = int'(w_h[idx]);
      if (w_done[idx]) cyc = edges;
      else if (edges >= limit) begin
        chk($sformatf("done_timeout[%0d]", idx), 0, 1);
        cyc = edges;
      end
      edges++;
    end
  endtask

  initial begin
    int c;
    int pk;
    rst = 1'b1;
    en  = 1'b0;
    vin = '0;
    @(posedge clk);
    armed = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_dist",   int'(w_dist[i]), 0);
      chk("reset_height", int'(w_h[i]),    0);
      chk("reset_done",   int'(w_done[i]), 0);
      chk("reset_air",    int'(w_air[i]),  0);
    end

    // v=1 on the 4-cycle tick: three ticks, lands at edge 12, done at 13.
    start(1);
    run_until_done(0, 100, c, pk);
    chk("v1_done_cycle", c, 13);
    chk("v1_dist", int'(w_dist[0]), 0);
    chk("v1_height", int'(w_h[0]), 0);
    // Hold enable: done must stay and the jump must not re-arm.
    repeat (20) @(negedge clk);
    chk("hold_done", int'(w_done[0]), 1);
    chk("hold_air", int'(w_air[0]), 0);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_done4", int'(w_done[0]), 0);
    chk("drop_done1", int'(w_done[1]), 0);
    repeat (2) @(negedge clk);

    // v=127 on the 1-cycle tick, then an out-of-range 600 that must match it.
    for (int t = 0; t < 2; t++) begin
      start((t == 0) ? 127 : 600);
      run_until_done(1, 400, c, pk);
      chk("v127_done_cycle", c, 256);
      chk("v127_peak", pk, 254);
      chk("v127_dist", int'(w_dist[1]), 253);
      chk("v127_height", int'(w_h[1]), 0);
      stop_jump(2);
    end

    // v=0: two ticks, nothing moves.
    start(0);
    run_until_done(0, 100, c, pk);
    chk("v0_done_cycle4", c, 9);
    chk("v0_done1", int'(w_done[1]), 1);
    chk("v0_dist", int'(w_dist[0]), 0);
    chk("v0_height", int'(w_h[0]), 0);
    stop_jump(2);

    // Abort at tick 10 with v=50: h_acc=455, dist_acc=500 freeze.
    start(50);
    repeat (42) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_height", int'(w_h[0]), 14);
    chk("abort_dist", int'(w_dist[0]), 3);
    chk("abort_done", int'(w_done[0]), 0);
    chk("abort_air", int'(w_air[0]), 0);
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("restart_height", int'(w_h[0]), 0);
    chk("restart_dist", int'(w_dist[0]), 0);
    chk("restart_air", int'(w_air[0]), 1);
    stop_jump(2);

    // Reset pulse mid-flight clears everything on the next edge.
    start(100);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_air", int'(w_air[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_dist",   int'(w_dist[i]), 0);
      chk("midrst_height", int'(w_h[i]),    0);
      chk("midrst_done",   int'(w_done[i]), 0);
      chk("midrst_air",    int'(w_air[i]),  0);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
